pool_out_writer: RTL



---
 rtl/pool_out_writer_pkg.sv | 14 +
 rtl/pool_out_writer_byte_max4.sv | 18 +
 rtl/pool_out_writer.sv | 101 ++++++++++
 3 files changed

// File: rtl/pool_out_writer_pkg.sv
// rtl/pool_out_writer_pkg.sv - shared types and constants for the pooled-output writer
package pool_out_writer_pkg;

  localparam int BYTE_W = 8;
  localparam int LANES  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/pool_out_writer_byte_max4.sv
// rtl/pool_out_writer_byte_max4.sv - lanewise unsigned max of two packed 4-byte words
module byte_max4
  import pool_out_writer_pkg::*;
(
  input  logic [LANES*BYTE_W-1:0] a,
  input  logic [LANES*BYTE_W-1:0] b,
  output logic [LANES*BYTE_W-1:0] y
);

  always_comb begin
    y = '0;
    for (int k = 0; k < LANES; k++) begin
      y[k*BYTE_W +: BYTE_W] = (a[k*BYTE_W +: BYTE_W] > b[k*BYTE_W +: BYTE_W])
                            ? a[k*BYTE_W +: BYTE_W] : b[k*BYTE_W +: BYTE_W];
    end
  end

endmodule

// File: rtl/pool_out_writer.sv
// rtl/pool_out_writer.sv - completes 2x2 max-pooling over conv rows and writes pooled words to SRAM
module pool_out_writer #(
  parameter int WORDS_PER_ROW = 4,
  parameter int ROWS_PER_MAP  = 8,
  parameter int ADDR_W        = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              conv_valid,
  input  logic [31:0]       conv_result,
  output logic              busy,
  output logic              done,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              drop_err
);
  import pool_out_writer_pkg::*;

  localparam int WC_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam int RC_W = $clog2(ROWS_PER_MAP);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] base_q;
  logic [WC_W-1:0]   word_cnt;
  logic [RC_W-1:0]   row_cnt;
  logic [31:0]       linebuf [WORDS_PER_ROW];
  logic [31:0]       pooled;
  logic [ADDR_W-1:0] wr_addr;
  logic              accept, last_word, last_row, start_ok, drop_now;

  byte_max4 u_max (
    .a (conv_result),
    .b (linebuf[word_cnt]),
    .y (pooled)
  );

  assign accept    = conv_valid && (state == EVEN || state == ODD);
  assign drop_now  = conv_valid && (state == IDLE || state == FIN);
  assign start_ok  = start && (state == IDLE);
  assign last_word = (word_cnt == WC_W'(WORDS_PER_ROW - 1));
  assign last_row  = (row_cnt == RC_W'(ROWS_PER_MAP - 1));
  // Each odd/even row pair produces one pooled row, hence row_cnt>>1.
  assign wr_addr   = base_q + ADDR_W'((32'(row_cnt) >> 1) * WORDS_PER_ROW) + ADDR_W'(word_cnt);

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    case (state)
      IDLE: if (start) state_nx = EVEN;
      EVEN: if (conv_valid && last_word) state_nx = ODD;
      ODD:  if (conv_valid && last_word) state_nx = last_row ? FIN : EVEN;
      FIN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q    <= '0;
      word_cnt  <= '0;
      row_cnt   <= '0;
      done      <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      drop_err  <= 1'b0;
      for (int i = 0; i < WORDS_PER_ROW; i++) linebuf[i] <= '0;
    end else begin
      mem_wen <= 1'b0;
      done    <= (state == FIN);
      // A dropped word in the start cycle must win over start's clear.
      if (drop_now)      drop_err <= 1'b1;
      else if (start_ok) drop_err <= 1'b0;
      if (start_ok) begin
        base_q   <= base_addr;
        word_cnt <= '0;
        row_cnt  <= '0;
      end
      if (accept) begin
        if (state == EVEN) begin
          linebuf[word_cnt] <= conv_result;
        end else begin
          mem_wen   <= 1'b1;
          mem_addr  <= wr_addr;
          mem_wdata <= pooled;
        end
        word_cnt <= last_word ? '0 : word_cnt + 1'b1;
        if (last_word) row_cnt <= row_cnt + 1'b1;
      end
    end
  end

endmodule
